adc_sample_sched: RTL and testbench
===================================

// Module: adc_sample_sched
// PURPOSE
// Sequencer for the voltmeter's SPI ADC front end. Issues periodic start pulses to the
// spi master (en), tracks each frame via ss, captures data_rec when the frame ends,
// and outputs every raw sample plus a boxcar average of 2**AVG_LOG2 samples for display.
// Sits between the spi master and the display/BCD path; handles transfer timeouts.
// PARAMETERS
// BITS      16     SPI frame width; must match spi #(.bits)
// DATA_W    12     ADC result width, taken from spi_data[DATA_W-1:0]
// DIV       100000 sample period in clk cycles (>= 4)
// AVG_LOG2  3      log2 of samples averaged (0..8); 0 = avg equals sample
// TIMEOUT   1024   max clk cycles allowed in each wait-for-ss state
// PORTS
// clk          in  1       system clock, all logic on rising edge
// rst          in  1       asynchronous, active-low reset (rst=0 resets)
// run          in  1       1 = continuous sampling enabled
// spi_en       out 1       one-cycle start pulse to spi master en
// spi_ss       in  1       spi master ss (low during frame)
// spi_data     in  BITS    spi master data_rec, valid once ss returns high
// sample       out DATA_W  last captured sample
// sample_valid out 1       one-cycle pulse when sample updates
// avg          out DATA_W  last completed average
// avg_valid    out 1       one-cycle pulse when avg updates
// busy         out 1       1 in any state except IDLE/WAIT_TICK
// overrun      out 1       sticky: tick arrived while a tick was already pending
// timeout_err  out 1       sticky: ss wait exceeded TIMEOUT; cleared when run=0
// BEHAVIOUR
// - Reset: state=IDLE; all outputs 0; period ctr, sample ctr, accumulator, pending=0.
// - Period ctr counts 0..DIV-1 while run=1, tick when ctr==DIV-1; held at 0 while run=0.
// - Tick sets pending; pending already set at tick -> overrun=1, tick dropped (1-deep).
// - FSM:
//   IDLE: run=1 -> WAIT_TICK. Clears overrun, timeout_err, acc, sample ctr while run=0.
//   WAIT_TICK: run=0 -> IDLE; pending=1 -> TRIG, pending cleared.
//   TRIG: spi_en=1 exactly this cycle -> WAIT_SS_LOW, wait ctr=0.
//   WAIT_SS_LOW: spi_ss==0 -> WAIT_SS_HIGH, wait ctr=0; ctr==TIMEOUT-1 -> TO_ERR.
//   WAIT_SS_HIGH: spi_ss==1 -> CAPTURE; ctr==TIMEOUT-1 -> TO_ERR.
//   CAPTURE: sample<=spi_data[DATA_W-1:0], sample_valid=1 next cycle; acc+=sample;
//     sample ctr++; -> WAIT_TICK if run=1 else IDLE.
//   TO_ERR: timeout_err=1; acc and sample ctr cleared (partial average dropped) -> WAIT_TICK/IDLE.
// - Average: acc width DATA_W+AVG_LOG2, no overflow possible. When sample ctr wraps
//   (2**AVG_LOG2 samples), avg<=(acc+sample)>>AVG_LOG2 (truncate), avg_valid pulses
//   in the same cycle as sample_valid, acc<=0.
// - Latency: spi_en 1 cycle after pending seen in WAIT_TICK; sample_valid 2 cycles after
//   ss rising edge is sampled high.
// - run dropped mid-frame: current frame completes and sample is output, then IDLE;
//   partial average discarded. Never abort spi mid-frame (no spi_en or ss forcing).
// - spi_ss already low in TRIG cycle is not treated as frame start; only sampled in WAIT_SS_LOW.
// - rst asserted mid-frame: immediate return to reset values; spi master reset on same rst.
// - busy=0 in IDLE/WAIT_TICK, 1 elsewhere. sample/avg hold between updates.
// TESTING (bench: BITS=16, DATA_W=12, DIV=50, AVG_LOG2=2, TIMEOUT=64, real spi model)
// 1 rst pulse low, run=0 -> all outputs 0, spi_en never pulses for 500 cycles.
// 2 run=1, miso stuck 1 -> spi_en every 50 cycles; sample=12'hFFF, sample_valid per frame;
//   after 4th frame avg=12'hFFF with avg_valid coincident with 4th sample_valid.
// 3 miso frames 0x0100,0x0200,0x0300,0x0401 -> avg=(0x100+0x200+0x300+0x401)>>2=12'h280.
// 4 spi_ss held high (no spi) -> 64 cycles after spi_en, timeout_err=1, no sample_valid;
//   run=0 then 1 -> timeout_err clears, sequencing resumes.
// 5 run=0 mid-frame after 2 samples -> frame completes, sample_valid once, no avg_valid,
//   state IDLE, busy=0; next run starts fresh 4-sample average.
// 6 DIV=4 with ~20-cycle frames -> overrun=1 sticky; rst=0 mid-frame -> all outputs 0 at once.

Source files
------------

// File: rtl/adc_sample_sched_if.sv
// Signal bundle between the ADC sample scheduler, the SPI master and the display path.
// The master modport is the scheduler; the slave side drives run and the SPI frame status.
interface adc_sample_sched_if #(
  parameter int BITS   = 16,
  parameter int DATA_W = 12
) ();
  logic              run;
  logic              spi_en;
  logic              spi_ss;
  logic [BITS-1:0]   spi_data;
  logic [DATA_W-1:0] sample;
  logic              sample_valid;
  logic [DATA_W-1:0] avg;
  logic              avg_valid;
  logic              busy;
  logic              overrun;
  logic              timeout_err;

  modport master (
    input  run, spi_ss, spi_data,
    output spi_en, sample, sample_valid, avg, avg_valid, busy, overrun, timeout_err
  );

  modport slave (
    output run, spi_ss, spi_data,
    input  spi_en, sample, sample_valid, avg, avg_valid, busy, overrun, timeout_err
  );
endinterface

// File: rtl/adc_sample_sched.sv
// Voltmeter ADC sequencer: periodic SPI frame start, frame tracking via ss with timeouts,
// raw sample capture and a boxcar average over 2**AVG_LOG2 samples.
module adc_sample_sched #(
  parameter int BITS     = 16,
  parameter int DATA_W   = 12,
  parameter int DIV      = 100000,
  parameter int AVG_LOG2 = 3,
  parameter int TIMEOUT  = 1024
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  adc_sample_sched_if.master bus
);

  localparam int PER_W    = $clog2(DIV);
  localparam int TO_W     = $clog2(TIMEOUT);
  localparam int CNT_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int ACC_W    = DATA_W + AVG_LOG2;
  localparam int LAST_CNT = (1 << AVG_LOG2) - 1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    TRIG,
    WAIT_SS_LOW,
    WAIT_SS_HIGH,
    CAPTURE,
    TO_ERR
  } state_e;

  state_e            state_q;
  logic [PER_W-1:0]  perCnt_q;
  logic              pending_q;
  logic [TO_W-1:0]   waitCnt_q;
  logic [CNT_W-1:0]  sampleCnt_q;
  logic [ACC_W-1:0]  acc_q;
  logic [DATA_W-1:0] sample_q;
  logic [DATA_W-1:0] avg_q;
  logic              spiEn_q;
  logic              sampleValid_q;
  logic              avgValid_q;
  logic              busy_q;
  logic              overrun_q;
  logic              timeoutErr_q;

  logic              tick;
  logic              take;
  logic              waitExpired;
  logic              lastSample;
  logic [DATA_W-1:0] newSample;
  logic [ACC_W-1:0]  sum_d;

  assign tick        = bus.run && (perCnt_q == PER_W'(DIV - 1));
  assign take        = (state_q == WAIT_TICK) && bus.run && pending_q;
  assign waitExpired = (waitCnt_q == TO_W'(TIMEOUT - 1));
  assign lastSample  = (sampleCnt_q == CNT_W'(LAST_CNT));
  assign newSample   = bus.spi_data[DATA_W-1:0];
  assign sum_d       = acc_q + ACC_W'(newSample);

  // Sample period counter; frozen at zero whenever sampling is disabled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perCnt_q <= '0;
    end else if (!bus.run || tick) begin
      perCnt_q <= '0;
    end else begin
      perCnt_q <= perCnt_q + PER_W'(1);
    end
  end

  // One-deep tick queue; a tick landing on a still-pending one is dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= 1'b0;
    end else if (!bus.run) begin
      pending_q <= 1'b0;
    end else begin
      pending_q <= tick | (pending_q & ~take);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      waitCnt_q     <= '0;
      sampleCnt_q   <= '0;
      acc_q         <= '0;
      sample_q      <= '0;
      avg_q         <= '0;
      spiEn_q       <= 1'b0;
      sampleValid_q <= 1'b0;
      avgValid_q    <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
      timeoutErr_q  <= 1'b0;
    end else begin
      spiEn_q       <= 1'b0;
      sampleValid_q <= 1'b0;
      avgValid_q    <= 1'b0;
      if (tick && pending_q && !take) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (bus.run) begin
            state_q <= WAIT_TICK;
          end else begin
            overrun_q    <= 1'b0;
            timeoutErr_q <= 1'b0;
            acc_q        <= '0;
            sampleCnt_q  <= '0;
          end
        end
        WAIT_TICK: begin
          if (!bus.run) begin
            state_q <= IDLE;
          end else if (pending_q) begin
            state_q <= TRIG;
            spiEn_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        TRIG: begin
          state_q   <= WAIT_SS_LOW;
          waitCnt_q <= '0;
        end
        WAIT_SS_LOW: begin
          if (!bus.spi_ss) begin
            state_q   <= WAIT_SS_HIGH;
            waitCnt_q <= '0;
          end else if (waitExpired) begin
            state_q      <= TO_ERR;
            timeoutErr_q <= 1'b1;
          end else begin
            waitCnt_q <= waitCnt_q + TO_W'(1);
          end
        end
        WAIT_SS_HIGH: begin
          if (bus.spi_ss) begin
            state_q <= CAPTURE;
          end else if (waitExpired) begin
            state_q      <= TO_ERR;
            timeoutErr_q <= 1'b1;
          end else begin
            waitCnt_q <= waitCnt_q + TO_W'(1);
          end
        end
        CAPTURE: begin
          sample_q      <= newSample;
          sampleValid_q <= 1'b1;
          // The closing sample joins the sum directly so avg lines up with sample_valid.
          if (lastSample) begin
            avg_q       <= DATA_W'(sum_d >> AVG_LOG2);
            avgValid_q  <= 1'b1;
            acc_q       <= '0;
            sampleCnt_q <= '0;
          end else begin
            acc_q       <= sum_d;
            sampleCnt_q <= sampleCnt_q + CNT_W'(1);
          end
          state_q <= bus.run ? WAIT_TICK : IDLE;
          busy_q  <= 1'b0;
        end
        TO_ERR: begin
          acc_q       <= '0;
          sampleCnt_q <= '0;
          state_q     <= bus.run ? WAIT_TICK : IDLE;
          busy_q      <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.spi_en       = spiEn_q;
  assign bus.sample       = sample_q;
  assign bus.sample_valid = sampleValid_q;
  assign bus.avg          = avg_q;
  assign bus.avg_valid    = avgValid_q;
  assign bus.busy         = busy_q;
  assign bus.overrun      = overrun_q;
  assign bus.timeout_err  = timeoutErr_q;

endmodule

// File: tb/tb_adc_sample_sched.sv
// Bench for adc_sample_sched: behavioural SPI slaves feed frames, and a scoreboard of
// expected samples/averages is filled as each frame ends and drained on sample_valid.
module tb_adc_sample_sched;
  localparam int BITS     = 16;
  localparam int DATA_W   = 12;
  localparam int DIV      = 50;
  localparam int AVG_LOG2 = 2;
  localparam int TIMEOUT  = 64;
  localparam int FRAME    = 20;

  typedef struct {
    logic [11:0] sample;
    bit          avgDue;
    logic [11:0] avg;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic rst4_n;

  int   checks = 0;
  int   errors = 0;
  int   sampleCount = 0;
  int   enCount = 0;
  int   modelAcc = 0;
  int   modelCnt = 0;
  int   n;
  int   savedCount;
  bit   spiEnable;
  logic [15:0] misoWord;
  logic [15:0] curWord;
  exp_t        sampleQ[$];
  logic [15:0] wordQ[$];

  always #5 clk = ~clk;

  adc_sample_sched_if #(.BITS(BITS), .DATA_W(DATA_W)) bus ();
  adc_sample_sched_if #(.BITS(BITS), .DATA_W(DATA_W)) bus4 ();

  adc_sample_sched #(
    .BITS(BITS), .DATA_W(DATA_W), .DIV(DIV), .AVG_LOG2(AVG_LOG2), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  adc_sample_sched #(
    .BITS(BITS), .DATA_W(DATA_W), .DIV(4), .AVG_LOG2(AVG_LOG2), .TIMEOUT(TIMEOUT)
  ) dut4 (
    .clk_i (clk),
    .rst_ni(rst4_n),
    .bus   (bus4)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic runVal, input int cycles);
    bus.run = runVal;
    repeat (cycles) @(negedge clk);
  endtask

  // Reference boxcar model: every fourth sample closes an average of the last four.
  task automatic pushExpected(input logic [15:0] word);
    exp_t e;
    e.sample = word[11:0];
    modelAcc += int'(word[11:0]);
    modelCnt++;
    e.avgDue = (modelCnt == 4);
    e.avg    = 12'(modelAcc / 4);
    if (e.avgDue) begin
      modelAcc = 0;
      modelCnt = 0;
    end
    sampleQ.push_back(e);
  endtask

  task automatic clearModel();
    modelAcc = 0;
    modelCnt = 0;
  endtask

  task automatic waitSampleTotal(input int target, input int budget, input string tag);
    int i = 0;
    while (sampleCount < target && i < budget) begin
      @(negedge clk);
      i++;
    end
    checkOutput(tag, sampleCount, target);
  endtask

  task automatic waitIdle(input string tag);
    int i = 0;
    while (bus.busy && i < 200) begin
      @(negedge clk);
      i++;
    end
    checkOutput(tag, bus.busy, 1'b0);
  endtask

  // SPI slave for the main DUT: ss drops right after the start pulse, rises FRAME cycles later.
  always begin
    @(negedge clk);
    if (rst_n && spiEnable && bus.spi_en) begin
      bus.spi_ss = 1'b0;
      repeat (FRAME) @(negedge clk);
      if (wordQ.size() > 0) curWord = wordQ.pop_front();
      else curWord = misoWord;
      bus.spi_data = curWord;
      bus.spi_ss   = 1'b1;
      pushExpected(curWord);
    end
  end

  // SPI slave for the fast-tick DUT; a reset ends the frame early.
  always begin
    @(negedge clk);
    if (rst4_n && bus4.spi_en) begin
      bus4.spi_ss = 1'b0;
      for (int i = 0; i < FRAME && rst4_n; i++) @(negedge clk);
      bus4.spi_data = 16'hA5C3;
      bus4.spi_ss   = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.spi_en) enCount++;
      if (bus.sample_valid) begin
        sampleCount++;
        if (sampleQ.size() == 0) begin
          checkOutput("sample_unexpected", bus.sample_valid, 1'b0);
        end else begin
          exp_t e;
          e = sampleQ.pop_front();
          checkOutput("sample", bus.sample, e.sample);
          checkOutput("avg_valid_align", bus.avg_valid, e.avgDue);
          if (e.avgDue) checkOutput("avg", bus.avg, e.avg);
        end
      end else if (bus.avg_valid) begin
        checkOutput("avg_valid_alone", bus.avg_valid, 1'b0);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    rst4_n        = 1'b0;
    spiEnable     = 1'b1;
    misoWord      = 16'hFFFF;
    bus.run       = 1'b0;
    bus.spi_ss    = 1'b1;
    bus.spi_data  = '0;
    bus4.run      = 1'b0;
    bus4.spi_ss   = 1'b1;
    bus4.spi_data = '0;
    repeat (3) @(negedge clk);

    // Reset state and idle behaviour
    checkOutput("rst_outputs",
                32'({bus.spi_en, bus.sample, bus.sample_valid, bus.avg, bus.avg_valid,
                     bus.overrun, bus.timeout_err}), 32'd0);
    checkOutput("rst_busy", bus.busy, 1'b0);
    rst_n = 1'b1;
    enCount = 0;
    applyStimulus(1'b0, 500);
    checkOutput("idle_no_en", enCount, 0);

    // Continuous sampling with miso stuck high
    savedCount = sampleCount;
    bus.run = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.spi_en && n < 100);
    checkOutput("first_en", bus.spi_en, 1'b1);
    @(negedge clk);
    checkOutput("en_one_cycle", bus.spi_en, 1'b0);
    n = 1;
    while (!bus.spi_en && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("en_period", n, DIV);
    waitSampleTotal(savedCount + 4, 400, "stuck1_frames");
    checkOutput("stuck1_avg", bus.avg, 12'hFFF);

    // Ramp frames, upper frame bits must be discarded
    wordQ.push_back(16'hF100);
    wordQ.push_back(16'h0200);
    wordQ.push_back(16'h0300);
    wordQ.push_back(16'h0401);
    waitSampleTotal(savedCount + 8, 400, "ramp_frames");
    checkOutput("ramp_avg", bus.avg, 12'h280);
    checkOutput("ramp_last_sample", bus.sample, 12'h401);
    applyStimulus(1'b0, 10);
    waitIdle("ramp_stop_idle");
    clearModel();

    // Transfer timeout with ss never falling
    spiEnable = 1'b0;
    savedCount = sampleCount;
    bus.run = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.spi_en && n < 100);
    checkOutput("to_en", bus.spi_en, 1'b1);
    repeat (60) @(negedge clk);
    checkOutput("to_not_early", bus.timeout_err, 1'b0);
    n = 0;
    while (!bus.timeout_err && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("to_err_set", bus.timeout_err, 1'b1);
    bus.run = 1'b0;
    waitIdle("to_idle");
    repeat (3) @(negedge clk);
    checkOutput("to_err_clear", bus.timeout_err, 1'b0);
    checkOutput("to_no_sample", sampleCount, savedCount);

    // Resume, then drop run in the middle of the third frame
    spiEnable = 1'b1;
    misoWord  = 16'h1234;
    clearModel();
    savedCount = sampleCount;
    bus.run = 1'b1;
    waitSampleTotal(savedCount + 2, 300, "resume_frames");
    n = 0;
    while (bus.spi_ss && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drop_midframe", bus.spi_ss, 1'b0);
    bus.run = 1'b0;
    waitSampleTotal(savedCount + 3, 100, "drop_frame_done");
    waitIdle("drop_idle");
    savedCount = sampleCount;
    repeat (150) @(negedge clk);
    checkOutput("drop_no_more", sampleCount, savedCount);
    clearModel();

    // Fresh four-sample average after restart
    wordQ.push_back(16'h0010);
    wordQ.push_back(16'h0020);
    wordQ.push_back(16'h0030);
    wordQ.push_back(16'h0040);
    bus.run = 1'b1;
    waitSampleTotal(savedCount + 4, 400, "fresh_frames");
    checkOutput("fresh_avg", bus.avg, 12'h028);
    applyStimulus(1'b0, 5);
    waitIdle("fresh_stop_idle");

    // Fast ticks against slow frames, then reset mid-frame
    rst4_n = 1'b1;
    @(negedge clk);
    bus4.run = 1'b1;
    n = 0;
    while (!bus4.sample_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("fast_sample", bus4.sample, 12'h5C3);
    n = 0;
    while (!bus4.overrun && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("overrun_set", bus4.overrun, 1'b1);
    repeat (30) @(negedge clk);
    checkOutput("overrun_sticky", bus4.overrun, 1'b1);
    n = 0;
    while (bus4.spi_ss && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("fast_midframe", bus4.spi_ss, 1'b0);
    rst4_n = 1'b0;
    #1;
    checkOutput("rst_midframe_outputs",
                32'({bus4.spi_en, bus4.sample, bus4.sample_valid, bus4.avg, bus4.avg_valid,
                     bus4.timeout_err}), 32'd0);
    checkOutput("rst_midframe_overrun", bus4.overrun, 1'b0);
    checkOutput("rst_midframe_busy", bus4.busy, 1'b0);

    checkOutput("scoreboard_drained", sampleQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
